// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared memory: grant in IDLE, MEM_LAT access cycles, one-cycle DONE.
// Latency MEM_LAT+1 from request to ready; a held request waits in IDLE until the FSM returns there.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int PRIORITY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  if (MEM_LAT < 1) begin : g_bad_lat
    $fatal(1, "mem_arbiter: MEM_LAT must be at least 1");
  end

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q;
  logic            owner_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic [CW-1:0]   cnt_q;

  logic            any_req;
  logic            grant;

  assign any_req = m0_req | m1_req;

  // Round-robin favours the port that did not win last; fixed priority always favours port 0.
  always_comb begin
    grant = 1'b0;
    if (m0_req && m1_req) begin
      grant = (PRIORITY != 0) ? 1'b0 : ~last_grant_q;
    end else if (m1_req) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_r    = 1'b0;
    mem_w    = 1'b0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy  = 1'b1;
        mem_r = ~we_q;
        // Write strobe only on the first access cycle so the memory commits exactly once.
        mem_w = we_q && (cnt_q == CNT_INIT);
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy     = 1'b1;
        m0_ready = ~owner_q;
        m1_ready = owner_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= grant;
            we_q    <= grant ? m1_we    : m0_we;
            addr_q  <= grant ? m1_addr  : m0_addr;
            wdata_q <= grant ? m1_wdata : m0_wdata;
            cnt_q   <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!we_q) begin
            rdata_q <= mem_rdata;
          end
        end
        S_DONE: begin
          last_grant_q <= owner_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign owner     = owner_q;

endmodule
